// File: rtl/clock_divider_pkg.sv
// Shared defaults and types for the programmable clock divider.
//
// Contents:
//   DIV_W_DEFAULT     default width of the divisor and period counter
//   RESET_DIV_DEFAULT default divisor in effect after reset
//   div_t             divisor type at the default width
package clock_divider_pkg;

  localparam int unsigned DIV_W_DEFAULT     = 8;
  localparam int unsigned RESET_DIV_DEFAULT = 3;

  typedef logic [DIV_W_DEFAULT-1:0] div_t;

endpackage

// File: rtl/half_cycle_ff.sv
// Falling-edge D flop with synchronous active-low reset. The divider uses it to
// delay the high phase by half a source cycle for odd divisors.
//
// Ports:
//   clk      source clock; state updates on its falling edge
//   reset_n  synchronous active-low reset, sampled on the falling edge
//   d        data in
//   q        data out
module half_cycle_ff (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  always_ff @(negedge clk) begin
    if (!reset_n) begin
      q <= 1'b0;
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/clock_divider_n.sv
// Programmable integer clock divider. Divides clk_i by a runtime-loadable N
// (1 .. 2^DIV_W-1). Divisor changes and enable changes take effect only at
// output-period boundaries, so clk_o never produces runt pulses.
//
// Build option: define CLOCK_DIVIDER_N_ODD_DUTY_EN to get 50 % duty for odd N
// via a falling-edge flop; otherwise the design is single-edge and odd N gives
// H high / H+1 low cycles.
//
// Ports:
//   clk_i       source clock
//   reset_ni    synchronous active-low reset
//   en_i        run request, sampled only at period boundaries
//   div_i       requested divisor
//   div_load_i  strobe capturing div_i into the pending register
//   div_ack_o   pulse in the cycle a pending divisor becomes active
//   div_err_o   pulse the cycle after a load with div_i == 0
//   cur_div_o   divisor currently in effect
//   active_o    divider running
//   tick_o      pulse in the first cycle of each clk_o period
//   clk_o       divided clock
module clock_divider_n
  import clock_divider_pkg::*;
#(
  parameter int unsigned DIV_W     = DIV_W_DEFAULT,
  parameter int unsigned RESET_DIV = RESET_DIV_DEFAULT
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic             en_i,
  input  logic [DIV_W-1:0] div_i,
  input  logic             div_load_i,
  output logic             div_ack_o,
  output logic             div_err_o,
  output logic [DIV_W-1:0] cur_div_o,
  output logic             active_o,
  output logic             tick_o,
  output logic             clk_o
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] cur_div_q, cur_div_d;
  logic [DIV_W-1:0] pend_div_q, pend_div_d;
  logic [DIV_W-1:0] next_div;
  logic             pend_q, pend_d;
  logic             hi_q, hi_d;
  logic             active_q, active_d;
  logic             tick_q, tick_d;
  logic             ack_q, ack_d;
  logic             err_q, err_d;
  logic             boundary;
  logic             slow_clk;

  always_comb begin
    // Every idle cycle counts as a boundary so pending loads and enables apply.
    boundary   = !active_q || (cnt_q == cur_div_q - DIV_W'(1));
    next_div   = pend_q ? pend_div_q : cur_div_q;

    cnt_d      = cnt_q + DIV_W'(1);
    cur_div_d  = cur_div_q;
    pend_d     = pend_q;
    pend_div_d = pend_div_q;
    active_d   = active_q;
    tick_d     = 1'b0;
    ack_d      = 1'b0;
    hi_d       = (cnt_q + DIV_W'(1)) < (cur_div_q >> 1);
    err_d      = div_load_i && (div_i == '0);

    if (boundary) begin
      cur_div_d = next_div;
      ack_d     = pend_q;
      pend_d    = 1'b0;
      active_d  = en_i;
      cnt_d     = '0;
      tick_d    = en_i;
      // High during cnt in [0, H); H is zero only for N == 1.
      hi_d      = en_i && ((next_div >> 1) != '0);
    end

    // Applied after the boundary update so a load on a boundary cycle stays
    // pending for the following boundary.
    if (div_load_i && (div_i != '0)) begin
      pend_d     = 1'b1;
      pend_div_d = div_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      cnt_q      <= '0;
      cur_div_q  <= DIV_W'(RESET_DIV);
      pend_div_q <= '0;
      pend_q     <= 1'b0;
      hi_q       <= 1'b0;
      active_q   <= 1'b0;
      tick_q     <= 1'b0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      cur_div_q  <= cur_div_d;
      pend_div_q <= pend_div_d;
      pend_q     <= pend_d;
      hi_q       <= hi_d;
      active_q   <= active_d;
      tick_q     <= tick_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
    end
  end

`ifdef CLOCK_DIVIDER_N_ODD_DUTY_EN
  logic hi_n;

  half_cycle_ff u_hi_n (
    .clk     (clk_i),
    .reset_n (reset_ni),
    .d       (hi_q),
    .q       (hi_n)
  );

  // hi_n stretches the high phase by half a cycle for odd N. It is gated by
  // active_q so a stale hi_n cannot show through in the half cycle after reset.
  assign slow_clk = cur_div_q[0] ? (hi_q | (hi_n & active_q)) : hi_q;
`else
  assign slow_clk = hi_q;
`endif

  // N == 1 cannot be built from posedge flops, so the source clock is passed.
  assign clk_o     = (cur_div_q == DIV_W'(1)) ? (clk_i & active_q) : slow_clk;

  assign div_ack_o = ack_q;
  assign div_err_o = err_q;
  assign cur_div_o = cur_div_q;
  assign active_o  = active_q;
  assign tick_o    = tick_q;

endmodule

// File: tb/tb_clock_divider_n.sv
// Self-checking bench for clock_divider_n: a table of per-cycle vectors run
// through a scoreboard queue, plus a duty-cycle measurement at N = 5.
module tb_clock_divider_n;
  import clock_divider_pkg::*;

`ifdef CLOCK_DIVIDER_N_ODD_DUTY_EN
  localparam logic ODD = 1'b1;
`else
  localparam logic ODD = 1'b0;
`endif

  logic clk_i = 1'b0;
  logic reset_ni;
  logic en_i;
  div_t div_i;
  logic div_load_i;
  logic div_ack_o;
  logic div_err_o;
  div_t cur_div_o;
  logic active_o;
  logic tick_o;
  logic clk_o;

  clock_divider_n #(
    .DIV_W     (8),
    .RESET_DIV (3)
  ) dut (
    .clk_i      (clk_i),
    .reset_ni   (reset_ni),
    .en_i       (en_i),
    .div_i      (div_i),
    .div_load_i (div_load_i),
    .div_ack_o  (div_ack_o),
    .div_err_o  (div_err_o),
    .cur_div_o  (cur_div_o),
    .active_o   (active_o),
    .tick_o     (tick_o),
    .clk_o      (clk_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic rst_n;
    logic en;
    logic load;
    div_t div;
    logic act;
    logic tick;
    logic clkp;  // clk_o in the first half of the cycle
    logic clkn;  // clk_o in the second half of the cycle
    logic ack;
    logic err;
    div_t cur;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  vec_t v;
  vec_t e;
  int   tests = 0;
  int   fails = 0;

  function automatic void add(logic rst_n, logic en, logic load, div_t div, logic act,
                              logic tick, logic clkp, logic clkn, logic ack, logic err,
                              div_t cur);
    vec_t r;
    r.rst_n = rst_n; r.en = en; r.load = load; r.div = div;
    r.act = act; r.tick = tick; r.clkp = clkp; r.clkn = clkn;
    r.ack = ack; r.err = err; r.cur = cur;
    vecs.push_back(r);
  endfunction

  function automatic void check(string name, int idx, logic [7:0] act, logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s step %0d: got %0d expected %0d", name, idx, act, exp);
    end
  endfunction

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int high;
    int ticks;
    int waited;

    // rst en ld div | act tick clkp clkn ack err cur
    add(0, 1, 0, 0,   0, 0, 0,   0, 0, 0, 3);  // reset
    add(0, 1, 0, 0,   0, 0, 0,   0, 0, 0, 3);
    add(1, 1, 0, 0,   1, 1, 1,   1, 0, 0, 3);  // start, N = 3
    add(1, 1, 0, 0,   1, 0, ODD, 0, 0, 0, 3);
    add(1, 1, 0, 0,   1, 0, 0,   0, 0, 0, 3);
    add(1, 1, 0, 0,   1, 1, 1,   1, 0, 0, 3);
    add(1, 1, 1, 4,   1, 0, ODD, 0, 0, 0, 3);  // load 4 at cnt 0
    add(1, 1, 0, 0,   1, 0, 0,   0, 0, 0, 3);
    add(1, 1, 0, 0,   1, 1, 1,   1, 1, 0, 4);  // ack, N = 4
    add(1, 1, 0, 0,   1, 0, 1,   1, 0, 0, 4);
    add(1, 1, 0, 0,   1, 0, 0,   0, 0, 0, 4);
    add(1, 1, 0, 0,   1, 0, 0,   0, 0, 0, 4);
    add(1, 1, 0, 0,   1, 1, 1,   1, 0, 0, 4);
    add(1, 1, 1, 5,   1, 0, 1,   1, 0, 0, 4);  // load 5
    add(1, 1, 1, 7,   1, 0, 0,   0, 0, 0, 4);  // overwrite with 7
    add(1, 1, 0, 0,   1, 0, 0,   0, 0, 0, 4);
    add(1, 1, 1, 6,   1, 1, 1,   1, 1, 0, 7);  // load 6 on boundary, 7 applies
    add(1, 1, 0, 0,   1, 0, 1,   1, 0, 0, 7);
    add(1, 1, 0, 0,   1, 0, 1,   1, 0, 0, 7);
    add(1, 1, 0, 0,   1, 0, ODD, 0, 0, 0, 7);
    add(1, 1, 0, 0,   1, 0, 0,   0, 0, 0, 7);
    add(1, 1, 0, 0,   1, 0, 0,   0, 0, 0, 7);
    add(1, 1, 0, 0,   1, 0, 0,   0, 0, 0, 7);
    add(1, 1, 0, 0,   1, 1, 1,   1, 1, 0, 6);  // 6 applies
    add(1, 1, 1, 0,   1, 0, 1,   1, 0, 1, 6);  // zero load -> err
    add(1, 1, 0, 0,   1, 0, 1,   1, 0, 0, 6);
    add(1, 1, 0, 0,   1, 0, 0,   0, 0, 0, 6);
    add(1, 1, 0, 0,   1, 0, 0,   0, 0, 0, 6);
    add(1, 1, 0, 0,   1, 0, 0,   0, 0, 0, 6);
    add(1, 1, 0, 0,   1, 1, 1,   1, 0, 0, 6);  // boundary, no ack
    add(1, 1, 1, 8,   1, 0, 1,   1, 0, 0, 6);  // load 8
    add(1, 1, 0, 0,   1, 0, 1,   1, 0, 0, 6);
    add(1, 1, 0, 0,   1, 0, 0,   0, 0, 0, 6);
    add(1, 1, 0, 0,   1, 0, 0,   0, 0, 0, 6);
    add(1, 1, 0, 0,   1, 0, 0,   0, 0, 0, 6);
    add(1, 1, 0, 0,   1, 1, 1,   1, 1, 0, 8);  // N = 8
    add(1, 1, 0, 0,   1, 0, 1,   1, 0, 0, 8);
    add(1, 0, 0, 0,   1, 0, 1,   1, 0, 0, 8);  // en dropped at cnt 1
    add(1, 0, 0, 0,   1, 0, 1,   1, 0, 0, 8);
    add(1, 0, 0, 0,   1, 0, 0,   0, 0, 0, 8);
    add(1, 0, 0, 0,   1, 0, 0,   0, 0, 0, 8);
    add(1, 0, 0, 0,   1, 0, 0,   0, 0, 0, 8);
    add(1, 0, 0, 0,   1, 0, 0,   0, 0, 0, 8);
    add(1, 0, 0, 0,   0, 0, 0,   0, 0, 0, 8);  // idle at boundary
    add(1, 0, 0, 0,   0, 0, 0,   0, 0, 0, 8);
    add(1, 0, 1, 1,   0, 0, 0,   0, 0, 0, 8);  // load 1 while idle
    add(1, 0, 0, 0,   0, 0, 0,   0, 1, 0, 1);  // applies while idle
    add(1, 1, 0, 0,   1, 1, 1,   0, 0, 0, 1);  // N = 1 follows clk_i
    add(1, 1, 0, 0,   1, 1, 1,   0, 0, 0, 1);
    add(1, 1, 1, 6,   1, 1, 1,   0, 0, 0, 1);  // load 6
    add(1, 1, 0, 0,   1, 1, 1,   1, 1, 0, 6);
    add(1, 1, 0, 0,   1, 0, 1,   1, 0, 0, 6);
    add(1, 1, 1, 9,   1, 0, 1,   1, 0, 0, 6);  // pending 9, then reset
    add(0, 1, 0, 0,   0, 0, 0,   0, 0, 0, 3);
    add(1, 0, 0, 0,   0, 0, 0,   0, 0, 0, 3);  // pending 9 was discarded
    add(1, 0, 0, 0,   0, 0, 0,   0, 0, 0, 3);

    for (int i = 0; i < vecs.size(); i++) begin
      v          = vecs[i];
      reset_ni   = v.rst_n;
      en_i       = v.en;
      div_load_i = v.load;
      div_i      = v.div;
      sb.push_back(v);
      @(posedge clk_i);
      #1;
      e = sb.pop_front();
      check("active_o", i, 8'(active_o), 8'(e.act));
      check("tick_o", i, 8'(tick_o), 8'(e.tick));
      check("clk_o_first_half", i, 8'(clk_o), 8'(e.clkp));
      check("div_ack_o", i, 8'(div_ack_o), 8'(e.ack));
      check("div_err_o", i, 8'(div_err_o), 8'(e.err));
      check("cur_div_o", i, cur_div_o, e.cur);
      @(negedge clk_i);
      #1;
      check("clk_o_second_half", i, 8'(clk_o), 8'(e.clkn));
    end

    // Duty measurement at N = 5 over two full periods.
    div_load_i = 1'b1;
    div_i      = 8'd5;
    en_i       = 1'b0;
    @(negedge clk_i);
    #1;
    div_load_i = 1'b0;
    en_i       = 1'b1;
    waited     = 0;
    @(posedge clk_i);
    #1;
    while (!tick_o && waited < 16) begin
      waited++;
      @(posedge clk_i);
      #1;
    end
    check("n5_start_tick", 0, 8'(tick_o), 8'd1);
    check("n5_cur_div", 0, cur_div_o, 8'd5);
    high  = 0;
    ticks = 0;
    for (int c = 0; c < 10; c++) begin
      if (clk_o) high++;
      if (tick_o) ticks++;
      @(negedge clk_i);
      #1;
      if (clk_o) high++;
      @(posedge clk_i);
      #1;
    end
    check("n5_high_half_cycles", 0, 8'(high), ODD ? 8'd10 : 8'd8);
    check("n5_ticks", 0, 8'(ticks), 8'd2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
